// File: rtl/adder_tree_in_packer.sv
// Serial-to-parallel input stage for the CSA adder tree.
// Collects I_DATA_N words into one frame (zero-padded when closed early by i_last)
// and presents it through a single output register with a valid/ready handshake.
module adder_tree_in_packer #(
   parameter int unsigned I_DATA_W = 3,
   parameter int unsigned I_DATA_N = 4,
   localparam int unsigned CNT_W = $clog2(I_DATA_N + 1)
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 i_valid,
   input  logic [I_DATA_W-1:0]                  i_data,
   input  logic                                 i_last,
   output logic                                 o_ready,
   output logic                                 o_valid,
   output logic [0:I_DATA_N-1][I_DATA_W-1:0]    o_data,
   output logic [CNT_W-1:0]                     o_words,
   input  logic                                 i_ready
);

   logic [0:I_DATA_N-1][I_DATA_W-1:0] r_buf;
   logic [CNT_W-1:0]                  r_cnt;
   logic                              r_valid;
   logic [0:I_DATA_N-1][I_DATA_W-1:0] r_data;
   logic [CNT_W-1:0]                  r_words;

   logic                              w_accept;
   logic                              w_xfer;
   logic                              w_complete;
   logic                              w_last_slot;
   logic [0:I_DATA_N-1][I_DATA_W-1:0] w_frame;

   // Handshake decode; o_ready depends only on registered o_valid and i_ready.
   always_comb begin
      o_ready     = !r_valid || i_ready;
      w_accept    = i_valid && o_ready;
      w_xfer      = r_valid && i_ready;
      w_last_slot = (r_cnt == CNT_W'(I_DATA_N - 1));
      w_complete  = w_accept && (i_last || w_last_slot);
   end

   // Buffered slots below cnt, new word at cnt, zeros above. Also the next buffer image
   // for a non-completing accept, since slots above cnt are kept zero.
   always_comb begin
      w_frame = '0;
      for (int i = 0; i < int'(I_DATA_N); i++) begin
         if (i < int'(r_cnt)) begin
            w_frame[i] = r_buf[i];
         end else if (i == int'(r_cnt)) begin
            w_frame[i] = i_data;
         end
      end
   end

   // Collect buffer and word counter; cleared whenever a frame completes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_buf <= '0;
         r_cnt <= '0;
      end else if (w_complete) begin
         r_buf <= '0;
         r_cnt <= '0;
      end else if (w_accept) begin
         r_buf <= w_frame;
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   // Output register: a new frame wins over a same-cycle transfer, keeping o_valid high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_words <= '0;
      end else if (w_complete) begin
         r_valid <= 1'b1;
         r_data  <= w_frame;
         r_words <= r_cnt + CNT_W'(1);
      end else if (w_xfer) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;
   assign o_words = r_words;

endmodule
